cdc_req_sender: RTL and testbench

//   Source-domain half of the 4-phase req/ack bus-transfer handshake.

---
 rtl/cdc_req_sender_pkg.sv | 16 +
 rtl/cdc_req_sender_bit_sync.sv | 26 ++
 rtl/cdc_req_sender.sv | 114 +++++++++++
 tb/tb_cdc_req_sender.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_req_sender_pkg.sv
// rtl/cdc_req_sender_pkg.sv - shared state encoding and defaults for the req/ack sender
package cdc_req_sender_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_REL  = ST_REL
   } state_t;

endpackage

// File: rtl/cdc_req_sender_bit_sync.sv
// rtl/cdc_req_sender_bit_sync.sv - single-bit multi-flop level synchroniser
module bit_sync
   import cdc_req_sender_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   // shift the asynchronous level through the flop chain; last flop is the safe copy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_req_sender.sv
// rtl/cdc_req_sender.sv - source-domain half of a 4-phase req/ack word transfer
module cdc_req_sender
   import cdc_req_sender_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int ACK_TIMEOUT = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] req_data,
   output logic                  req_lvl,
   input  logic                  ack_lvl,
   output logic                  busy,
   output logic                  done_pulse,
   output logic                  timeout_err
);

   // ACK_TIMEOUT of zero disables expiry entirely; the counter then just free-runs in REQ
   localparam bit                   TIMEOUT_EN = (ACK_TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_WIDTH'(ACK_TIMEOUT - 1)
                                                             : '0;

   state_t                  state, state_nxt;
   logic                    ack_s;
   logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0]   data_q, data_nxt;
   logic                    req_q, req_nxt;
   logic                    done_q, done_nxt;
   logic                    to_q, to_nxt;

   // ack_lvl is only ever looked at through this synchroniser
   bit_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk(clk),
      .rst(rst),
      .d  (ack_lvl),
      .q  (ack_s)
   );

   // registered state, held word, request level, counter and pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         data_q <= '0;
         req_q  <= 1'b0;
         done_q <= 1'b0;
         to_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         data_q <= data_nxt;
         req_q  <= req_nxt;
         done_q <= done_nxt;
         to_q   <= to_nxt;
      end
   end

   // next-state logic; ack is tested before expiry so a coincident ack wins
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      data_nxt  = data_q;
      req_nxt   = req_q;
      done_nxt  = 1'b0;
      to_nxt    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               data_nxt  = in_data;
               req_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
            if (ack_s) begin
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = S_REL;
            end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
               req_nxt   = 1'b0;
               to_nxt    = 1'b1;
               state_nxt = S_REL;
            end
         end
         S_REL: begin
            req_nxt = 1'b0;
            if (!ack_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign in_ready    = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign req_lvl     = req_q;
   assign req_data    = data_q;
   assign done_pulse  = done_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_cdc_req_sender.sv
// tb/tb_cdc_req_sender.sv - self-checking bench for cdc_req_sender
module tb_cdc_req_sender;

   localparam int SA   = 2;
   localparam int SB   = 3;
   localparam int TO_A = 10;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] in_data_a, req_data_a;
   logic       in_valid_a, in_ready_a, req_lvl_a, ack_lvl_a, busy_a, done_a, to_a;
   logic [7:0] in_data_b, req_data_b;
   logic       in_valid_b, in_ready_b, req_lvl_b, ack_lvl_b, busy_b, done_b, to_b;

   cdc_req_sender #(
      .DATA_WIDTH(8), .SYNC_STAGES(SA), .ACK_TIMEOUT(TO_A), .CNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .req_data(req_data_a), .req_lvl(req_lvl_a), .ack_lvl(ack_lvl_a), .busy(busy_a),
      .done_pulse(done_a), .timeout_err(to_a)
   );

   cdc_req_sender #(
      .DATA_WIDTH(8), .SYNC_STAGES(SB), .ACK_TIMEOUT(0), .CNT_WIDTH(16)
   ) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .req_data(req_data_b), .req_lvl(req_lvl_b), .ack_lvl(ack_lvl_b), .busy(busy_b),
      .done_pulse(done_b), .timeout_err(to_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       ack;
      logic       rdy;
      logic       req;
      logic [7:0] rdat;
      logic       bsy;
      logic       dn;
      logic       to;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic ak,
                               input logic rdy, input logic req, input logic [7:0] rd,
                               input logic bsy, input logic dn, input logic to);
      vec_t r;
      r.valid = v;  r.data = d;  r.ack = ak;
      r.rdy = rdy;  r.req = req; r.rdat = rd;
      r.bsy = bsy;  r.dn = dn;   r.to = to;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_a(input string tag, input logic rdy, input logic req, input logic [7:0] dat,
                        input logic bsy, input logic dn, input logic to);
      chk({tag, "/in_ready"}, 32'(in_ready_a), 32'(rdy));
      chk({tag, "/req_lvl"}, 32'(req_lvl_a), 32'(req));
      chk({tag, "/req_data"}, 32'(req_data_a), 32'(dat));
      chk({tag, "/busy"}, 32'(busy_a), 32'(bsy));
      chk({tag, "/done_pulse"}, 32'(done_a), 32'(dn));
      chk({tag, "/timeout_err"}, 32'(to_a), 32'(to));
   endtask

   // ack raised d cycles before the expiry edge: rise_ofs 8 lands on the expiry edge, 9 misses it
   task automatic race_case(input int rise_ofs, input logic exp_done, input logic [7:0] dat);
      int a;
      in_valid_a = 1'b1;
      in_data_a  = dat;
      a = cyc + 1;
      while (cyc < a + 14) begin
         @(negedge clk);
         if (cyc == a) begin
            in_valid_a = 1'b0;
            chk_a("race_acc", 0, 1, dat, 1, 0, 0);
         end
         if (cyc == a + rise_ofs - 1) ack_lvl_a = 1'b1;
         if (cyc == a + 9)  chk_a("race_pre", 0, 1, dat, 1, 0, 0);
         if (cyc == a + 10) chk_a("race_exp", 0, 0, dat, 1, exp_done, !exp_done);
         if (cyc == a + 11) begin
            chk_a("race_post", 0, 0, dat, 1, 0, 0);
            ack_lvl_a = 1'b0;
         end
         if (cyc == a + 13) chk_a("race_rel", 0, 0, dat, 1, 0, 0);
         if (cyc == a + 14) chk_a("race_idle", 1, 0, dat, 0, 0, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] tx[$];
      logic [7:0] rx[$];
      int         n_done, n_to;

      rst = 1'b0;
      in_valid_a = 0; in_data_a = 0; ack_lvl_a = 0;
      in_valid_b = 0; in_data_b = 0; ack_lvl_b = 0;

      tbl[0] = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0);
      for (int i = 1; i <= 2; i++) tbl[i] = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 1, 0, 0);
      for (int i = 3; i <= 4; i++) tbl[i] = mk(1, 8'h3C, 1, 0, 1, 8'hA5, 1, 0, 0);
      tbl[5] = mk(1, 8'h3C, 1, 0, 0, 8'hA5, 1, 1, 0);
      for (int i = 6; i <= 7; i++) tbl[i] = mk(1, 8'h3C, 1, 0, 0, 8'hA5, 1, 0, 0);
      for (int i = 8; i <= 9; i++) tbl[i] = mk(1, 8'h3C, 0, 0, 0, 8'hA5, 1, 0, 0);
      tbl[10] = mk(1, 8'h3C, 0, 1, 0, 8'hA5, 0, 0, 0);
      tbl[11] = mk(1, 8'h3C, 0, 0, 1, 8'h3C, 1, 0, 0);
      for (int i = 12; i <= 20; i++) tbl[i] = mk(0, 8'h00, 0, 0, 1, 8'h3C, 1, 0, 0);
      tbl[21] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 1, 0, 1);
      tbl[22] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 0, 0, 0);

      repeat (2) @(negedge clk);
      chk_a("reset", 1, 0, 8'h00, 0, 0, 0);
      chk("reset_b/req_lvl", 32'(req_lvl_b), 0);
      chk("reset_b/in_ready", 32'(in_ready_b), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_a("post_reset", 1, 0, 8'h00, 0, 0, 0);

      // asynchronous reset in the middle of a request
      in_valid_a = 1'b1;
      in_data_a  = 8'h77;
      @(negedge clk);
      in_valid_a = 1'b0;
      chk_a("rst_mid_acc", 0, 1, 8'h77, 1, 0, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_a("rst_mid_async", 1, 0, 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_a("rst_mid_idle", 1, 0, 8'h00, 0, 0, 0);

      // normal transfer, busy-ignore of a held word, then timeout
      for (int i = 0; i < 23; i++) begin
         in_valid_a = tbl[i].valid;
         in_data_a  = tbl[i].data;
         ack_lvl_a  = tbl[i].ack;
         @(negedge clk);
         chk_a($sformatf("row%0d", i), tbl[i].rdy, tbl[i].req, tbl[i].rdat,
               tbl[i].bsy, tbl[i].dn, tbl[i].to);
      end

      race_case(8, 1'b1, 8'h5A);
      race_case(9, 1'b0, 8'hC3);

      // ack already high when the word is offered
      ack_lvl_a = 1'b1;
      repeat (3) @(negedge clk);
      chk_a("ackhigh_idle", 1, 0, 8'hC3, 0, 0, 0);
      begin
         int a;
         in_valid_a = 1'b1;
         in_data_a  = 8'h96;
         a = cyc + 1;
         while (cyc < a + 4) begin
            @(negedge clk);
            if (cyc == a) begin
               in_valid_a = 1'b0;
               chk_a("ackhigh_acc", 0, 1, 8'h96, 1, 0, 0);
            end
            if (cyc == a + 1) begin
               chk_a("ackhigh_done", 0, 0, 8'h96, 1, 1, 0);
               ack_lvl_a = 1'b0;
            end
            if (cyc == a + 3) chk_a("ackhigh_rel", 0, 0, 8'h96, 1, 0, 0);
            if (cyc == a + 4) chk_a("ackhigh_idle2", 1, 0, 8'h96, 0, 0, 0);
         end
      end

      // randomised stream on the 3-stage instance, timing predicted from the latency rules
      n_done = 0;
      n_to   = 0;
      for (int w = 0; w < 16; w++) begin
         int         gap, d1, d2, a, mr, pf, fin;
         logic [7:0] word;
         logic       got;
         gap  = $urandom_range(0, 3);
         d1   = $urandom_range(0, 7);
         d2   = $urandom_range(0, 7);
         word = 8'($urandom_range(0, 255));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("stream_gap/in_ready", 32'(in_ready_b), 1);
            chk("stream_gap/req_lvl", 32'(req_lvl_b), 0);
         end
         tx.push_back(word);
         in_valid_b = 1'b1;
         in_data_b  = word;
         a   = cyc + 1;
         mr  = a + d1 + 1;
         pf  = mr + SB + d2 + 1;
         fin = pf + SB;
         got = 1'b0;
         while (cyc < fin) begin
            @(negedge clk);
            if (cyc == a) in_valid_b = 1'b0;
            if (!got && req_lvl_b) begin
               rx.push_back(req_data_b);
               got = 1'b1;
            end
            if (done_b) n_done++;
            if (to_b) n_to++;
            chk($sformatf("stream_w%0d/req_lvl", w), 32'(req_lvl_b), 32'(cyc < mr + SB));
            chk($sformatf("stream_w%0d/busy", w), 32'(busy_b), 32'(cyc < fin));
            chk($sformatf("stream_w%0d/in_ready", w), 32'(in_ready_b), 32'(cyc >= fin));
            chk($sformatf("stream_w%0d/done_pulse", w), 32'(done_b), 32'(cyc == mr + SB));
            chk($sformatf("stream_w%0d/req_data", w), 32'(req_data_b), 32'(word));
            if (cyc == mr - 1) ack_lvl_b = 1'b1;
            if (cyc == pf - 1) ack_lvl_b = 1'b0;
         end
      end
      chk("stream/words_seen", 32'(rx.size()), 16);
      for (int i = 0; i < 16 && i < rx.size(); i++)
         chk($sformatf("stream/order%0d", i), 32'(rx[i]), 32'(tx[i]));
      chk("stream/done_count", 32'(n_done), 16);
      chk("stream/timeout_count", 32'(n_to), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
